pc_gen: RTL and testbench

Parametrised program-counter generator for the fetch stage of the MIPS core. It is the successor of the fixed 32-bit free-running PC: the address width, reset vector and instruction step are configurable. It adds a valid/ready fetch handshake with instruction memory, stall re-fetch, branch redirect with a one-entry pending buffer, and a pipeline flush. It sits between the control/branch logic (ID/EX) and the instruction ROM interface.

---
 rtl/pc_gen_pkg.sv | 16 +
 rtl/pc_redirect_buf.sv | 29 ++
 rtl/pc_gen.sv | 143 ++++++++++++++
 tb/tb_pc_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared constants and FSM encoding for the fetch-stage program counter.
package pc_gen_pkg;

  localparam logic        RstEnable   = 1'b1;
  localparam logic        ChipEnable  = 1'b1;
  localparam logic        ChipDisable = 1'b0;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam int          InstAddrBus = 32;

  typedef enum logic [1:0] {
    PcStBoot  = 2'd0,
    PcStRun   = 2'd1,
    PcStFlush = 2'd2
  } pc_st_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry pending redirect register: write/overwrite wins over clear; zero latency to read.
// No backpressure: a younger write simply replaces the stored target.
module pc_redirect_buf
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W = InstAddrBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              clr,
  input  logic [ADDR_W-1:0] wdat,
  output logic              vld,
  output logic [ADDR_W-1:0] dat
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      vld <= 1'b0;
      dat <= '0;
    end else if (wr) begin
      vld <= 1'b1;
      dat <= wdat;
    end else if (clr) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: valid/ready fetch, stall re-fetch, pending branch, flush; outputs registered, 1-cycle redirect.
// pc_o holds while fetch_valid_o=1 and fetch_ready_i=0; optional PC_MISALIGN_CHECK_EN aligns redirect targets.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int          ADDR_W     = InstAddrBus,
  parameter logic [31:0] RESET_PC   = ZeroWord,
  parameter int          INST_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  input  logic              fetch_ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              ce_o,
  output logic              fetch_valid_o,
  output logic              misalign_o
);

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(INST_BYTES);

  pc_st_e            state, state_n;
  logic [ADDR_W-1:0] pc_n;
  logic              ce_n, vld_n, mis_n;
  logic              fire;
  logic              pend_wr, pend_clr, pend_vld;
  logic [ADDR_W-1:0] pend_dat;
  logic [ADDR_W-1:0] br_tgt, fl_tgt;
  logic              br_mis, fl_mis;

`ifdef PC_MISALIGN_CHECK_EN
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INST_BYTES - 1);

  assign br_tgt = branch_target_i & ~LOW_MASK;
  assign fl_tgt = new_pc_i & ~LOW_MASK;
  assign br_mis = |(branch_target_i & LOW_MASK);
  assign fl_mis = |(new_pc_i & LOW_MASK);
`else
  assign br_tgt = branch_target_i;
  assign fl_tgt = new_pc_i;
  assign br_mis = 1'b0;
  assign fl_mis = 1'b0;
`endif

  assign fire = fetch_valid_o & fetch_ready_i;

  always_comb begin
    state_n  = state;
    pc_n     = pc_o;
    ce_n     = ce_o;
    vld_n    = fetch_valid_o;
    mis_n    = 1'b0;
    pend_wr  = 1'b0;
    pend_clr = 1'b0;
    unique case (state)
      PcStBoot: begin
        ce_n = ChipEnable;
        if (flush_i) begin
          pc_n     = fl_tgt;
          mis_n    = fl_mis;
          vld_n    = 1'b0;
          pend_clr = 1'b1;
          state_n  = PcStFlush;
        end else begin
          vld_n   = 1'b1;
          state_n = PcStRun;
        end
      end
      PcStRun: begin
        if (flush_i) begin
          pc_n     = fl_tgt;
          mis_n    = fl_mis;
          vld_n    = 1'b0;
          pend_clr = 1'b1;
          state_n  = PcStFlush;
        end else if (fire && stall_i) begin
          // Re-fetch the same pc; a concurrent branch must wait for the next fire.
          pend_wr = branch_flag_i;
          mis_n   = branch_flag_i & br_mis;
        end else if (fire && branch_flag_i) begin
          pc_n     = br_tgt;
          mis_n    = br_mis;
          pend_clr = 1'b1;
        end else if (fire && pend_vld) begin
          pc_n     = pend_dat;
          pend_clr = 1'b1;
        end else if (fire) begin
          pc_n = pc_o + STEP;
        end else if (branch_flag_i) begin
          pend_wr = 1'b1;
          mis_n   = br_mis;
        end
      end
      PcStFlush: begin
        if (flush_i) begin
          pc_n     = fl_tgt;
          mis_n    = fl_mis;
          pend_clr = 1'b1;
        end else begin
          vld_n   = 1'b1;
          state_n = PcStRun;
        end
      end
      default: begin
        state_n = PcStBoot;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state         <= PcStBoot;
      pc_o          <= RST_PC;
      ce_o          <= ChipDisable;
      fetch_valid_o <= 1'b0;
      misalign_o    <= 1'b0;
    end else begin
      state         <= state_n;
      pc_o          <= pc_n;
      ce_o          <= ce_n;
      fetch_valid_o <= vld_n;
      misalign_o    <= mis_n;
    end
  end

  pc_redirect_buf #(
    .ADDR_W(ADDR_W)
  ) u_redirect_buf (
    .clk  (clk),
    .rst  (rst),
    .wr   (pend_wr),
    .clr  (pend_clr),
    .wdat (br_tgt),
    .vld  (pend_vld),
    .dat  (pend_dat)
  );

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed literal checks plus randomized traffic against a behavioural model.
module tb_pc_gen;

  localparam int INST_BYTES = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] new_pc_i = '0;
  logic        fetch_ready_i = 1'b1;
  logic [31:0] pc_o;
  logic        ce_o;
  logic        fetch_valid_o;
  logic        misalign_o;

  int passed = 0;
  int total  = 0;
  bit chk_en = 1'b0;

  pc_gen #(
    .ADDR_W     (32),
    .RESET_PC   (32'h0000_0000),
    .INST_BYTES (INST_BYTES)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .flush_i         (flush_i),
    .new_pc_i        (new_pc_i),
    .fetch_ready_i   (fetch_ready_i),
    .pc_o            (pc_o),
    .ce_o            (ce_o),
    .fetch_valid_o   (fetch_valid_o),
    .misalign_o      (misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] fix(input logic [31:0] a);
`ifdef PC_MISALIGN_CHECK_EN
    return a - (a % INST_BYTES);
`else
    return a;
`endif
  endfunction

  function automatic logic bad(input logic [31:0] a);
`ifdef PC_MISALIGN_CHECK_EN
    return (a % INST_BYTES) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Behavioural model: mode 0 = waiting after reset, 1 = fetching, 2 = flush bubble.
  int          m_mode = 0;
  logic [31:0] m_pc   = '0;
  logic        m_ce   = 1'b0;
  logic        m_vld  = 1'b0;
  logic        m_mis  = 1'b0;
  logic [31:0] m_pend[$];
  logic        m_fire;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_pc = '0; m_ce = 1'b0; m_vld = 1'b0; m_mis = 1'b0;
      m_pend.delete();
    end else begin
      m_fire = m_vld && fetch_ready_i;
      m_mis  = 1'b0;
      if (m_mode == 0) begin
        m_ce = 1'b1;
        if (flush_i) begin
          m_pc = fix(new_pc_i); m_mis = bad(new_pc_i); m_vld = 1'b0; m_mode = 2;
        end else begin
          m_vld = 1'b1; m_mode = 1;
        end
      end else if (flush_i) begin
        m_pc = fix(new_pc_i); m_mis = bad(new_pc_i); m_vld = 1'b0; m_mode = 2;
        m_pend.delete();
      end else if (m_mode == 2) begin
        m_vld = 1'b1; m_mode = 1;
      end else if (m_fire && stall_i) begin
        if (branch_flag_i) begin
          m_pend.delete(); m_pend.push_back(fix(branch_target_i)); m_mis = bad(branch_target_i);
        end
      end else if (m_fire && branch_flag_i) begin
        m_pc = fix(branch_target_i); m_mis = bad(branch_target_i); m_pend.delete();
      end else if (m_fire && m_pend.size() != 0) begin
        m_pc = m_pend.pop_front();
      end else if (m_fire) begin
        m_pc = m_pc + INST_BYTES;
      end else if (branch_flag_i) begin
        m_pend.delete(); m_pend.push_back(fix(branch_target_i)); m_mis = bad(branch_target_i);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_pc", pc_o, m_pc);
      chk("cmp_ce", 32'(ce_o), 32'(m_ce));
      chk("cmp_vld", 32'(fetch_valid_o), 32'(m_vld));
      chk("cmp_mis", 32'(misalign_o), 32'(m_mis));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_tgt();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return r & 32'hFFFF_FFFC;
      1:       return r;
      2:       return 32'hFFFF_FFF0 | (r & 32'h0000_000C);
      default: return r & 32'h0000_0FFC;
    endcase
  endfunction

  initial begin
    tick(); tick();
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_ce", 32'(ce_o), 32'h0);
    chk("rst_vld", 32'(fetch_valid_o), 32'h0);
    chk("rst_mis", 32'(misalign_o), 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    tick();
    chk("boot_pc", pc_o, 32'h0);
    chk("boot_ce", 32'(ce_o), 32'h1);
    chk("boot_vld", 32'(fetch_valid_o), 32'h1);
    tick(); chk("seq_4", pc_o, 32'h4);
    tick(); chk("seq_8", pc_o, 32'h8);
    tick(); chk("seq_c", pc_o, 32'hC);
    tick(); chk("seq_10", pc_o, 32'h10);

    fetch_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("nordy_pc", pc_o, 32'h10);
      chk("nordy_vld", 32'(fetch_valid_o), 32'h1);
    end
    fetch_ready_i = 1'b1;
    tick(); chk("rdy_14", pc_o, 32'h14);
    repeat (3) tick();
    chk("at_20", pc_o, 32'h20);

    fetch_ready_i = 1'b0; branch_flag_i = 1'b1; branch_target_i = 32'h100;
    tick(); chk("pend_hold", pc_o, 32'h20);
    branch_flag_i = 1'b0; fetch_ready_i = 1'b1;
    tick(); chk("pend_take", pc_o, 32'h100);
    tick(); chk("pend_next", pc_o, 32'h104);

    flush_i = 1'b1; new_pc_i = 32'h180; branch_flag_i = 1'b1; branch_target_i = 32'h200;
    tick();
    chk("flush_pc", pc_o, 32'h180);
    chk("flush_bubble", 32'(fetch_valid_o), 32'h0);
    flush_i = 1'b0; branch_flag_i = 1'b0;
    tick();
    chk("flush_resume_pc", pc_o, 32'h180);
    chk("flush_resume_vld", 32'(fetch_valid_o), 32'h1);
    tick(); chk("flush_next", pc_o, 32'h184);

    flush_i = 1'b1; new_pc_i = 32'h40;
    tick(); flush_i = 1'b0;
    tick(); chk("stall_at_40", pc_o, 32'h40);
    stall_i = 1'b1;
    tick(); chk("stall_refetch", pc_o, 32'h40);
    stall_i = 1'b0;
    tick(); chk("stall_next", pc_o, 32'h44);

    flush_i = 1'b1; new_pc_i = 32'hFFFF_FFFC;
    tick(); flush_i = 1'b0;
    tick(); chk("wrap_top", pc_o, 32'hFFFF_FFFC);
    tick(); chk("wrap_zero", pc_o, 32'h0);

    branch_flag_i = 1'b1; branch_target_i = 32'h102;
    tick();
`ifdef PC_MISALIGN_CHECK_EN
    chk("mis_pc", pc_o, 32'h100);
    chk("mis_pulse", 32'(misalign_o), 32'h1);
`else
    chk("mis_pc", pc_o, 32'h102);
    chk("mis_pulse", 32'(misalign_o), 32'h0);
`endif
    branch_flag_i = 1'b0;
    tick(); chk("mis_end", 32'(misalign_o), 32'h0);

    fetch_ready_i = 1'b0; branch_flag_i = 1'b1; branch_target_i = 32'h300;
    tick(); branch_flag_i = 1'b0;
    rst = 1'b1;
    #2;
    chk("arst_pc", pc_o, 32'h0);
    chk("arst_vld", 32'(fetch_valid_o), 32'h0);
    rst = 1'b0; fetch_ready_i = 1'b1;
    tick(); chk("arst_boot", pc_o, 32'h0);
    tick(); chk("arst_no_pend", pc_o, 32'h4);

    for (int i = 0; i < 3000; i++) begin
      stall_i         = ($urandom_range(0, 99) < 20);
      fetch_ready_i   = ($urandom_range(0, 99) < 70);
      branch_flag_i   = ($urandom_range(0, 99) < 15);
      flush_i         = ($urandom_range(0, 99) < 5);
      branch_target_i = rnd_tgt();
      new_pc_i        = rnd_tgt();
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        #2;
        rst = 1'b0;
      end
      tick();
    end

    stall_i = 1'b0; branch_flag_i = 1'b0; flush_i = 1'b0; fetch_ready_i = 1'b1;
    repeat (3) tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
